config_bus_master: RTL
======================

// Module: config_bus_master
// PURPOSE
//  Bus master for the shared 32-bit GPIO configuration bus that feeds the config_reg slaves.
//  It arbitrates round-robin between num_req internal requesters.
//  Each granted request is one full register write: a target address and num_words bytes.
//  It sends the bytes MSB-first as a sequence of setup / w_clk-high / w_clk-low phases.
//  Each byte is clocked in by the slave on a w_clk rising edge.
//  The slave then waits for w_clk to return low before it accepts the next byte.
// PARAMETERS
//  word_width  8   bits per bus data field (must equal GPIO data field width, 8)
//  num_words   4   bytes per register write
//  addr_width  16  bits per bus address field (must equal GPIO addr field width, 16)
//  num_req     2   number of requesters (>=1)
//  setup_cyc   2   clk cycles addr/data are stable with w_clk low before the rising edge (>=1)
//  high_cyc    2   clk cycles w_clk is held high (>=1)
//  low_cyc     2   clk cycles w_clk is held low after the high phase, addr/data still held (>=1)
// PORTS
//  clk        in   1                            system clock; everything is on its rising edge
//  rst        in   1                            synchronous reset, active-high
//  req_valid  in   num_req                      per-requester write request; held until req_ready
//  req_addr   in   num_req*addr_width           target bus_addr, requester i at [i*addr_width +: addr_width]
//  req_data   in   num_req*num_words*word_width register value, MSB byte sent first
//  req_ready  out  num_req                      one-cycle accept pulse, one-hot or zero
//  gpio_out   out  32                           [15:0] addr, [23:16] data, [24] w_clk, [31:25] always 0
//  busy       out  1                            high from the cycle after an accept until the done cycle
//  done       out  1                            one-cycle pulse when the last byte's low phase completes
//  grant_id   out  $clog2(num_req) (min 1)      index of the requester being served; valid while busy
// BEHAVIOUR
//  Reset: req_ready=0, gpio_out=0, busy=0, done=0, grant_id=0, RR pointer=0, state=IDLE.
//   - Reset asserted mid-transfer aborts the transfer.
//   - Outputs are at their reset values on the edge after rst is sampled high.
//   - A partially shifted slave is left as-is; software rewrites it.
//  States:
//   - IDLE: gpio_out=0. If any req_valid, the winner gets req_ready=1 this cycle.
//     The winner's addr/data are latched into the shift register and byte_idx=0. Next state SETUP.
//   - SETUP: addr field = latched addr, data field = current MSB byte, w_clk=0.
//     Lasts setup_cyc cycles, then HIGH.
//   - HIGH: same addr/data, w_clk=1. Lasts high_cyc cycles, then LOW.
//   - LOW: same addr/data, w_clk=0. Lasts low_cyc cycles.
//     On exit, if byte_idx<num_words-1: shift the data left by word_width, byte_idx++, go to SETUP.
//     Otherwise go to IDLE and pulse done=1 in the first IDLE cycle.
//  Timing:
//   - Accept in cycle N. w_clk first rises in cycle N+1+setup_cyc.
//   - done is in cycle N+1+num_words*(setup_cyc+high_cyc+low_cyc).
//   - A new accept may happen in the done cycle, so back-to-back writes are possible.
//  Addr and data never change while w_clk=1, or in the cycle w_clk rises or falls.
//  One phase counter, width $clog2(max(setup_cyc,high_cyc,low_cyc)+1), reloaded on each phase entry.
//  Arbitration:
//   - Search starts at the RR pointer and wraps modulo num_req; the first asserted req_valid wins.
//   - After a grant, pointer = winner+1 (mod num_req). With num_req=1 the pointer stays 0.
//   - Simultaneous requests are served in that order. No requester waits more than num_req-1 transfers.
//   - req_valid is ignored outside IDLE. A requester dropping req_valid before it is granted is not an error.
//   - req_ready is never asserted outside IDLE or during reset.
//  Requester data is sampled only in the accept cycle; later changes have no effect.
// TESTING
//  T1 reset: random req_valid with rst=1 for 5 cycles -> gpio_out=0, req_ready=0, busy=0, done=0 every cycle.
//  T2 single write, defaults: req0 addr=0x0003, data=0xA1B2C3D4, accepted cycle N
//   -> w_clk rises in cycles N+3, N+9, N+15, N+21; data field A1, B2, C3, D4; addr=0x0003 throughout.
//   -> done in cycle N+25. A config_reg model at bus_addr 3 reads 0xA1B2C3D4.
//  T3 contention: req0 and req1 asserted together and held, pointer=0 -> req0 served first, then req1.
//   -> req1 is accepted in req0's done cycle; grant_id goes 0 then 1.
//   -> With both held continuously, grants alternate 0,1,0,1.
//  T4 hold checks: setup_cyc=1, high_cyc=3, low_cyc=1
//   -> the checker sees no addr/data change while w_clk=1, 5 cycles per byte, done at N+1+4*5.
//  T5 reset mid-op: rst=1 during the HIGH phase of byte 2
//   -> next cycle gpio_out=0, busy=0, no done pulse. A later request restarts at byte 0 (MSB).
//  T6 ignore while busy: req1 data changes while req0 is being served
//   -> req1's new value is what gets transmitted once req1 is granted. req_ready[1] stays 0 until req0's done cycle.

Source files
------------

// File: rtl/config_bus_master.sv
// config_bus_master
// Drives the shared 32-bit GPIO configuration bus used by the config_reg slaves.
// The block arbitrates round-robin between num_req requesters. Each grant sends
// one full register write: num_words bytes, MSB first, to the latched address.
// Every byte goes out as a setup / w_clk-high / w_clk-low phase sequence.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   req_valid  per-requester write request, held until req_ready
//   req_addr   packed target addresses, requester i at [i*addr_width +: addr_width]
//   req_data   packed register values, requester i at [i*num_words*word_width +: ...]
//   req_ready  one-cycle accept pulse, one-hot or zero
//   gpio_out   [15:0] addr, [23:16] data, [24] w_clk, [31:25] zero
//   busy       high while a write is in progress
//   done       one-cycle pulse in the first idle cycle after the last byte
//   grant_id   index of the requester being served
module config_bus_master #(
    parameter int unsigned word_width = 8,
    parameter int unsigned num_words  = 4,
    parameter int unsigned addr_width = 16,
    parameter int unsigned num_req    = 2,
    parameter int unsigned setup_cyc  = 2,
    parameter int unsigned high_cyc   = 2,
    parameter int unsigned low_cyc    = 2,
    localparam int unsigned IdW       = (num_req > 1) ? $clog2(num_req) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [num_req-1:0]                    req_valid,
    input  logic [num_req*addr_width-1:0]         req_addr,
    input  logic [num_req*num_words*word_width-1:0] req_data,
    output logic [num_req-1:0]                    req_ready,
    output logic [31:0]                           gpio_out,
    output logic                                  busy,
    output logic                                  done,
    output logic [IdW-1:0]                        grant_id
);

    localparam int unsigned DataW  = num_words * word_width;
    localparam int unsigned MaxSh  = (setup_cyc > high_cyc) ? setup_cyc : high_cyc;
    localparam int unsigned MaxCyc = (MaxSh > low_cyc) ? MaxSh : low_cyc;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned ByteW  = (num_words > 1) ? $clog2(num_words) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StHigh, StLow} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [ByteW-1:0]       byte_idx_q, byte_idx_d;
    logic [DataW-1:0]       shift_q, shift_d;
    logic [addr_width-1:0]  addr_q, addr_d;
    logic [IdW-1:0]         grant_q, grant_d;
    logic [IdW-1:0]         ptr_q, ptr_d;
    logic                   done_q, done_d;

    logic [addr_width-1:0]  req_addr_arr [num_req];
    logic [DataW-1:0]       req_data_arr [num_req];
    logic                   found;
    logic [IdW-1:0]         winner;
    logic [IdW-1:0]         cand;
    logic [IdW-1:0]         ptr_next;
    int unsigned            idx;

    always_comb begin
        for (int unsigned i = 0; i < num_req; i++) begin
            req_addr_arr[i] = req_addr[i*addr_width +: addr_width];
            req_data_arr[i] = req_data[i*DataW +: DataW];
        end
    end

    // Round-robin search starting at the pointer; first asserted request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 0; k < num_req; k++) begin
            idx  = (32'(ptr_q) + k) % num_req;
            cand = IdW'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        ptr_next = (winner == IdW'(num_req - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        done_d     = 1'b0;
        req_ready  = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    addr_d     = req_addr_arr[winner];
                    shift_d    = req_data_arr[winner];
                    byte_idx_d = '0;
                    grant_d    = winner;
                    ptr_d      = ptr_next;
                    cnt_d      = CntW'(setup_cyc - 1);
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(high_cyc - 1);
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHigh: begin
                if (cnt_q == '0) begin
                    cnt_d   = CntW'(low_cyc - 1);
                    state_d = StLow;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLow: begin
                if (cnt_q == '0) begin
                    if (byte_idx_q == ByteW'(num_words - 1)) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        shift_d    = shift_q << word_width;
                        byte_idx_d = byte_idx_q + 1'b1;
                        cnt_d      = CntW'(setup_cyc - 1);
                        state_d    = StSetup;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // The accept must not be seen by a requester while the FSM is being reset.
        if (rst) req_ready = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        gpio_out = '0;
        if (state_q != StIdle) begin
            gpio_out[addr_width-1:0]             = addr_q;
            gpio_out[addr_width +: word_width]   = shift_q[DataW-1 -: word_width];
            gpio_out[addr_width + word_width]    = (state_q == StHigh);
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign grant_id = grant_q;

endmodule
